// File: rtl/mem_arbiter_2p.sv
// rtl/mem_arbiter_2p.sv - two-requester arbiter/sequencer in front of one memory; ARB_ROUND_ROBIN_EN selects round-robin grant
module mem_arbiter_2p #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_v,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [31:0]     req0_adr,
    input  logic [XLEN-1:0] req0_wdata,
    input  logic [3:0]      req0_strobe,
    output logic [XLEN-1:0] req0_rdata,
    output logic            req0_resp_v,
    output logic            req0_err,
    input  logic            req1_v,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [31:0]     req1_adr,
    input  logic [XLEN-1:0] req1_wdata,
    input  logic [3:0]      req1_strobe,
    output logic [XLEN-1:0] req1_rdata,
    output logic            req1_resp_v,
    output logic            req1_err,
    output logic            mem_r_v,
    output logic            mem_w_v,
    output logic [31:0]     mem_adr,
    output logic [XLEN-1:0] mem_data,
    output logic [3:0]      mem_strobe,
    input  logic [XLEN-1:0] mem_resp,
    input  logic            mem_resp_valid,
    input  logic            mem_resp_error,
    output logic            busy
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic [31:0]            adr_q, adr_d;
    logic [XLEN-1:0]        wdata_q, wdata_d;
    logic [3:0]             strobe_q, strobe_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             resp_v_q, resp_v_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][XLEN-1:0]   rdata_q, rdata_d;
    logic                   winner;
    logic                   accept;

`ifdef ARB_ROUND_ROBIN_EN
    logic                   last_grant_q, last_grant_d;
    assign winner = (req0_v && req1_v) ? !last_grant_q : !req0_v;
`else
    assign winner = !req0_v;
`endif

    assign accept     = (state_q == IDLE) && (req0_v || req1_v);
    assign req0_ready = rst_n && accept && !winner;
    assign req1_ready = rst_n && accept && winner;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        strobe_d = strobe_q;
        cnt_d    = cnt_q;
        resp_v_d = '0;
        err_d    = '0;
        rdata_d  = '0;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    owner_d  = winner;
                    we_d     = winner ? req1_we     : req0_we;
                    adr_d    = winner ? req1_adr    : req0_adr;
                    wdata_d  = winner ? req1_wdata  : req0_wdata;
                    strobe_d = winner ? req1_strobe : req0_strobe;
                    state_d  = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = winner;
`endif
                end
            end
            ISSUE: begin
                if (we_q) begin
                    resp_v_d[owner_q] = 1'b1;
                    err_d[owner_q]    = mem_resp_error;
                    state_d           = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A real response takes precedence over an expiring timeout.
                if (mem_resp_valid) begin
                    resp_v_d[owner_q] = 1'b1;
                    err_d[owner_q]    = mem_resp_error;
                    rdata_d[owner_q]  = mem_resp;
                    state_d           = IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    resp_v_d[owner_q] = 1'b1;
                    err_d[owner_q]    = 1'b1;
                    state_d           = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            strobe_q <= '0;
            cnt_q    <= '0;
            resp_v_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
            resp_v_q <= resp_v_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign mem_r_v     = (state_q == ISSUE) && !we_q;
    assign mem_w_v     = (state_q == ISSUE) && we_q;
    assign mem_adr     = adr_q;
    assign mem_data    = wdata_q;
    assign mem_strobe  = strobe_q;
    assign busy        = (state_q != IDLE);
    assign req0_resp_v = resp_v_q[0];
    assign req1_resp_v = resp_v_q[1];
    assign req0_err    = err_q[0];
    assign req1_err    = err_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// tb/tb_mem_arbiter_2p.sv - directed self-checking bench for mem_arbiter_2p
module tb_mem_arbiter_2p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_v, req0_ready, req0_we, req0_resp_v, req0_err;
    logic [31:0] req0_adr, req0_wdata, req0_rdata;
    logic [3:0]  req0_strobe;
    logic        req1_v, req1_ready, req1_we, req1_resp_v, req1_err;
    logic [31:0] req1_adr, req1_wdata, req1_rdata;
    logic [3:0]  req1_strobe;
    logic        mem_r_v, mem_w_v, mem_resp_valid, mem_resp_error, busy;
    logic [31:0] mem_adr, mem_data, mem_resp;
    logic [3:0]  mem_strobe;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_g;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.XLEN(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_v(req0_v), .req0_ready(req0_ready), .req0_we(req0_we), .req0_adr(req0_adr),
        .req0_wdata(req0_wdata), .req0_strobe(req0_strobe), .req0_rdata(req0_rdata),
        .req0_resp_v(req0_resp_v), .req0_err(req0_err),
        .req1_v(req1_v), .req1_ready(req1_ready), .req1_we(req1_we), .req1_adr(req1_adr),
        .req1_wdata(req1_wdata), .req1_strobe(req1_strobe), .req1_rdata(req1_rdata),
        .req1_resp_v(req1_resp_v), .req1_err(req1_err),
        .mem_r_v(mem_r_v), .mem_w_v(mem_w_v), .mem_adr(mem_adr), .mem_data(mem_data),
        .mem_strobe(mem_strobe), .mem_resp(mem_resp), .mem_resp_valid(mem_resp_valid),
        .mem_resp_error(mem_resp_error), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req0_v = 0; req0_we = 0; req0_adr = 0; req0_wdata = 0; req0_strobe = 0;
        req1_v = 0; req1_we = 0; req1_adr = 0; req1_wdata = 0; req1_strobe = 0;
        mem_resp = 0; mem_resp_valid = 0; mem_resp_error = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_mem_r_v", mem_r_v, 0);
        chk("rst_mem_w_v", mem_w_v, 0);
        chk("rst_mem_adr", mem_adr, 0);
        chk("rst_resp_v", {req1_resp_v, req0_resp_v}, 0);
        rst_n = 1'b1;

        // port 0 read, memory answers one cycle after mem_r_v
        @(negedge clk); req0_v = 1; req0_we = 0; req0_adr = 32'h20010; #1;
        chk("rd_ready0", req0_ready, 1);
        chk("rd_ready1", req1_ready, 0);
        @(negedge clk); req0_v = 0; req1_v = 1; #1;
        chk("rd_mem_r_v", mem_r_v, 1);
        chk("rd_mem_w_v", mem_w_v, 0);
        chk("rd_mem_adr", mem_adr, 32'h20010);
        chk("rd_busy", busy, 1);
        chk("rd_no_accept_busy", req1_ready, 0);
        @(negedge clk); req1_v = 0; mem_resp_valid = 1; mem_resp = 32'hDEADBEEF; #1;
        chk("rd_resp_not_yet", req0_resp_v, 0);
        @(negedge clk); mem_resp_valid = 0; mem_resp = 0; #1;
        chk("rd_resp_v", req0_resp_v, 1);
        chk("rd_rdata", req0_rdata, 32'hDEADBEEF);
        chk("rd_err", req0_err, 0);
        chk("rd_other_resp", req1_resp_v, 0);
        chk("rd_idle", busy, 0);

        // port 1 write
        @(negedge clk); req1_v = 1; req1_we = 1; req1_adr = 32'h20004;
        req1_wdata = 32'h12345678; req1_strobe = 4'b0011; #1;
        chk("wr_ready1", req1_ready, 1);
        chk("wr_ready0", req0_ready, 0);
        @(negedge clk); req1_v = 0; #1;
        chk("wr_mem_w_v", mem_w_v, 1);
        chk("wr_mem_r_v", mem_r_v, 0);
        chk("wr_strobe", mem_strobe, 4'b0011);
        chk("wr_data", mem_data, 32'h12345678);
        chk("wr_adr", mem_adr, 32'h20004);
        @(negedge clk); #1;
        chk("wr_resp_v", req1_resp_v, 1);
        chk("wr_err", req1_err, 0);
        chk("wr_rdata", req1_rdata, 0);
        chk("wr_other_resp", req0_resp_v, 0);
        @(negedge clk); #1;
        chk("wr_resp_pulse", req1_resp_v, 0);

        // simultaneous reads, four rounds, from a fresh reset
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        req1_we = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_g = (i % 2 == 0);
`else
            exp_g = 1'b0;
`endif
            @(negedge clk);
            req0_v = 1; req1_v = 1; req0_we = 0; req1_we = 0;
            req0_adr = 32'h1000 + 32'(i * 4); req1_adr = 32'h2000 + 32'(i * 4); #1;
            chk("arb_ready0", req0_ready, !exp_g);
            chk("arb_ready1", req1_ready, exp_g);
            @(negedge clk); req0_v = 0; req1_v = 0; #1;
            chk("arb_adr", mem_adr, exp_g ? 32'h2000 + 32'(i * 4) : 32'h1000 + 32'(i * 4));
            @(negedge clk); mem_resp_valid = 1; mem_resp = 32'hA0 + 32'(i);
            @(negedge clk); mem_resp_valid = 0; mem_resp = 0; #1;
            chk("arb_resp0", req0_resp_v, !exp_g);
            chk("arb_resp1", req1_resp_v, exp_g);
            chk("arb_rdata", exp_g ? req1_rdata : req0_rdata, 32'hA0 + 32'(i));
        end

        // read timeout: no response ever
        @(negedge clk); req0_v = 1; req0_we = 0; req0_adr = 32'h40; mem_resp = 32'hCAFE;
        @(negedge clk); req0_v = 0;
        repeat (16) @(negedge clk);
        #1;
        chk("to_busy_before", busy, 1);
        chk("to_resp_before", req0_resp_v, 0);
        @(negedge clk); #1;
        chk("to_resp_v", req0_resp_v, 1);
        chk("to_err", req0_err, 1);
        chk("to_rdata", req0_rdata, 0);
        chk("to_busy_after", busy, 0);
        mem_resp = 0;

        // read with memory error, then a stale response in IDLE
        @(negedge clk); req0_v = 1; req0_adr = 32'h50;
        @(negedge clk); req0_v = 0;
        @(negedge clk); mem_resp_valid = 1; mem_resp_error = 1; mem_resp = 32'h55;
        @(negedge clk); mem_resp_valid = 0; mem_resp_error = 0; mem_resp = 0; #1;
        chk("err_resp_v", req0_resp_v, 1);
        chk("err_flag", req0_err, 1);
        chk("err_rdata", req0_rdata, 32'h55);
        @(negedge clk); mem_resp_valid = 1; mem_resp = 32'h99;
        @(negedge clk); mem_resp_valid = 0; mem_resp = 0; #1;
        chk("stale_resp", {req1_resp_v, req0_resp_v}, 0);
        chk("stale_busy", busy, 0);

        // reset while waiting for a read
        @(negedge clk); req0_v = 1; req0_adr = 32'h60;
        @(negedge clk); req0_v = 0;
        @(negedge clk); #1;
        chk("rstw_busy_before", busy, 1);
        rst_n = 0; #1;
        chk("rstw_busy", busy, 0);
        chk("rstw_mem_adr", mem_adr, 0);
        chk("rstw_mem_r_v", mem_r_v, 0);
        chk("rstw_resp", {req1_resp_v, req0_resp_v}, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk); mem_resp_valid = 1; mem_resp = 32'h77;
        @(negedge clk); mem_resp_valid = 0; mem_resp = 0; #1;
        chk("rstw_no_resp", {req1_resp_v, req0_resp_v}, 0);
        @(negedge clk); req1_v = 1; req1_we = 0; req1_adr = 32'h80; #1;
        chk("fresh_ready1", req1_ready, 1);
        @(negedge clk); req1_v = 0; #1;
        chk("fresh_adr", mem_adr, 32'h80);
        @(negedge clk); mem_resp_valid = 1; mem_resp = 32'h1234;
        @(negedge clk); mem_resp_valid = 0; mem_resp = 0; #1;
        chk("fresh_resp_v", req1_resp_v, 1);
        chk("fresh_rdata", req1_rdata, 32'h1234);
        chk("fresh_err", req1_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
